// File: rtl/bounded_deque.sv
// Bounded double-ended queue on a circular buffer; one op per handshake, one response beat per op.
// Define BOUNDED_DEQUE_INSERT_EN to build INSERT (opcode 6) with its element-shifting FSM.
`timescale 1ns/1ps

module bounded_deque #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 256,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] op_data,
    input  logic [IDX_W-1:0] op_idx,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic [IDX_W:0]   size,
    output logic             empty,
    output logic             full
);

    localparam logic [2:0] OP_NOP        = 3'd0;
    localparam logic [2:0] OP_PUSH_BACK  = 3'd1;
    localparam logic [2:0] OP_PUSH_FRONT = 3'd2;
    localparam logic [2:0] OP_POP_FRONT  = 3'd3;
    localparam logic [2:0] OP_POP_BACK   = 3'd4;
    localparam logic [2:0] OP_DELETE     = 3'd5;
    localparam logic [2:0] OP_INSERT     = 3'd6;

    localparam logic [IDX_W:0]   DEPTH_C  = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0]   SIZE_ONE = (IDX_W+1)'(1'b1);
    localparam logic [IDX_W-1:0] PTR_ONE  = IDX_W'(1'b1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W:0]   size_q, size_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;

    logic             mem_we_s;
    logic [IDX_W-1:0] mem_waddr_s;
    logic [WIDTH-1:0] mem_wdata_s;
    logic             accept_s;
    logic [IDX_W-1:0] tail_ptr_s;
    logic [IDX_W-1:0] back_ptr_s;

`ifdef BOUNDED_DEQUE_INSERT_EN
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0] ins_idx_q, ins_idx_d;
    logic [WIDTH-1:0] ins_data_q, ins_data_d;
    logic [IDX_W:0]   ins_k_s;
    logic             ins_bad_s;
    logic [IDX_W-1:0] move_dst_s;

    assign op_ready  = (state_q == ST_IDLE);
    assign ins_k_s   = size_q - {1'b0, op_idx};
    assign ins_bad_s = ({1'b0, op_idx} > size_q) || full_q;
`else
    logic unused_idx_s;

    assign op_ready     = 1'b1;
    assign unused_idx_s = ^op_idx;
`endif

    assign accept_s   = op_valid && op_ready;
    assign tail_ptr_s = head_q + size_q[IDX_W-1:0];
    assign back_ptr_s = tail_ptr_s - PTR_ONE;

    // Next-state for pointers, count, response and the single storage write port
    always_comb begin
        head_d      = head_q;
        size_d      = size_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        mem_we_s    = 1'b0;
        mem_waddr_s = '0;
        mem_wdata_s = '0;
`ifdef BOUNDED_DEQUE_INSERT_EN
        state_d     = state_q;
        cnt_d       = cnt_q;
        ins_idx_d   = ins_idx_q;
        ins_data_d  = ins_data_q;
        move_dst_s  = '0;

        // Shift walks from the back toward the insertion point, one element per cycle
        if (state_q == ST_SHIFT) begin
            if (cnt_q != '0) begin
                move_dst_s  = head_q + ins_idx_q + cnt_q[IDX_W-1:0];
                mem_we_s    = 1'b1;
                mem_waddr_s = move_dst_s;
                mem_wdata_s = mem_q[move_dst_s - PTR_ONE];
                cnt_d       = cnt_q - SIZE_ONE;
            end else begin
                mem_we_s    = 1'b1;
                mem_waddr_s = head_q + ins_idx_q;
                mem_wdata_s = ins_data_q;
                size_d      = size_q + SIZE_ONE;
                rsp_valid_d = 1'b1;
                rsp_data_d  = '0;
                rsp_err_d   = 1'b0;
                state_d     = ST_IDLE;
            end
        end else
`endif
        if (accept_s) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            rsp_err_d   = 1'b0;
            case (op_code)
                OP_NOP: begin
                    rsp_err_d = 1'b0;
                end
                OP_PUSH_BACK: begin
                    if (full_q) begin
                        rsp_err_d = 1'b1;
                    end else begin
                        mem_we_s    = 1'b1;
                        mem_waddr_s = tail_ptr_s;
                        mem_wdata_s = op_data;
                        size_d      = size_q + SIZE_ONE;
                    end
                end
                OP_PUSH_FRONT: begin
                    if (full_q) begin
                        rsp_err_d = 1'b1;
                    end else begin
                        mem_we_s    = 1'b1;
                        mem_waddr_s = head_q - PTR_ONE;
                        mem_wdata_s = op_data;
                        head_d      = head_q - PTR_ONE;
                        size_d      = size_q + SIZE_ONE;
                    end
                end
                OP_POP_FRONT: begin
                    if (empty_q) begin
                        rsp_err_d = 1'b1;
                    end else begin
                        rsp_data_d = mem_q[head_q];
                        head_d     = head_q + PTR_ONE;
                        size_d     = size_q - SIZE_ONE;
                    end
                end
                OP_POP_BACK: begin
                    if (empty_q) begin
                        rsp_err_d = 1'b1;
                    end else begin
                        rsp_data_d = mem_q[back_ptr_s];
                        size_d     = size_q - SIZE_ONE;
                    end
                end
                OP_DELETE: begin
                    head_d = '0;
                    size_d = '0;
                end
                OP_INSERT: begin
`ifdef BOUNDED_DEQUE_INSERT_EN
                    if (ins_bad_s) begin
                        rsp_err_d = 1'b1;
                    end else if (ins_k_s == '0) begin
                        mem_we_s    = 1'b1;
                        mem_waddr_s = tail_ptr_s;
                        mem_wdata_s = op_data;
                        size_d      = size_q + SIZE_ONE;
                    end else begin
                        // First move happens in the accept cycle so the data write fits in the last shift cycle
                        rsp_valid_d = 1'b0;
                        rsp_data_d  = rsp_data_q;
                        rsp_err_d   = rsp_err_q;
                        move_dst_s  = head_q + op_idx + ins_k_s[IDX_W-1:0];
                        mem_we_s    = 1'b1;
                        mem_waddr_s = move_dst_s;
                        mem_wdata_s = mem_q[move_dst_s - PTR_ONE];
                        cnt_d       = ins_k_s - SIZE_ONE;
                        ins_idx_d   = op_idx;
                        ins_data_d  = op_data;
                        state_d     = ST_SHIFT;
                    end
`else
                    rsp_err_d = 1'b1;
`endif
                end
                default: begin
                    rsp_err_d = 1'b1;
                end
            endcase
        end else begin
            rsp_valid_d = 1'b0;
        end

        empty_d = (size_d == '0);
        full_d  = (size_d == DEPTH_C);
    end

    // Control and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q      <= '0;
            size_q      <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            head_q      <= head_d;
            size_q      <= size_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef BOUNDED_DEQUE_INSERT_EN
    // Insert FSM state and latched operands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ins_idx_q  <= '0;
            ins_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ins_idx_q  <= ins_idx_d;
            ins_data_q <= ins_data_d;
        end
    end
`endif

    // Element storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign size      = size_q;
    assign empty     = empty_q;
    assign full      = full_q;

endmodule
